// File: rtl/simd_issuer_pkg.sv
// Shared definitions for the SIMD issuer: address/instruction types,
// processor instruction opcodes and SIMD operation codes.
package simd_issuer_pkg;

    localparam int ADDR_W       = 32;
    localparam int INSTR_DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    // Processor instruction opcodes; NOP is the all-zero idle encoding.
    typedef enum logic [1:0] {
        INSTR_NOP  = 2'd0,
        INSTR_LD   = 2'd1,
        INSTR_INFO = 2'd2,
        INSTR_FIN  = 2'd3
    } instr_op_t;

    typedef struct packed {
        instr_op_t                op;
        logic [INSTR_DATA_W-1:0]  data;
    } instr_t;

    // SIMD command operation codes carried in the command
    localparam logic [1:0] SIMD_OP_ADD  = 2'd0;
    localparam logic [1:0] SIMD_OP_MUL  = 2'd1;
    localparam logic [1:0] SIMD_OP_SUB  = 2'd2;
    localparam logic [1:0] SIMD_OP_RSVD = 2'd3;

    function automatic instr_t make_instr(input instr_op_t op,
                                          input logic [INSTR_DATA_W-1:0] data);
        instr_t r;
        r.op   = op;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/simd_issuer_cmd_fifo.sv
// Command FIFO with a registered head word. The head register always holds
// the oldest entry, so a consumer can inspect it before popping; a word
// pushed into an empty FIFO becomes visible one cycle after the push.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == CNT_MAX);
    assign o_empty = (count_q == '0);
    assign o_head  = head_q;
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    // Pointer/occupancy update and next head selection (bypass when the pushed word becomes head)
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
        head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? i_wdata : mem[rd_ptr_d];
    end

    // Storage array write, no reset so it can map onto RAM
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= i_wdata;
        end
    end

    // Control and head registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/simd_issuer.sv
// SIMD command issuer: queues vector commands and feeds each one to the
// processor as LD addr0, LD addr1, INFO, then waits for finish and sends FIN.
// Note: CNT_W + 2 must not exceed INSTR_DATA_W so count and op fit in INFO.
module simd_issuer
    import simd_issuer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  addr_t            i_cmd_addr0,
    input  addr_t            i_cmd_addr1,
    input  logic [CNT_W-1:0] i_cmd_count,
    input  logic [1:0]       i_cmd_op,
    output logic             o_en,
    output logic             o_valid,
    output instr_t           o_instr,
    input  logic             i_ack,
    input  logic             i_busy,
    input  logic             i_finish,
    output logic             o_done,
    output logic             o_err,
    output logic [7:0]       o_done_cnt
);
    localparam int CMD_W = 2*ADDR_W + CNT_W + 2;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_EN           = 3'd1;
    localparam logic [2:0] ST_SEND         = 3'd2;
    localparam logic [2:0] ST_GAP          = 3'd3;
    localparam logic [2:0] ST_WAIT_FIN     = 3'd4;
    localparam logic [2:0] ST_FIN_ACK      = 3'd5;
    localparam logic [2:0] ST_FIN_WAIT_LOW = 3'd6;

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0] fifo_head;
    addr_t            head_addr0, head_addr1;
    logic [CNT_W-1:0] head_count;
    logic [1:0]       head_op;

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    addr_t            addr0_q, addr0_d, addr1_q, addr1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             ack_prev_q, ack_prev_d;
    logic             done_q, done_d, err_q, err_d;
    logic [7:0]       done_cnt_q, done_cnt_d;
    logic             ack_rise;
    logic [INSTR_DATA_W-1:0] info_word;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (i_cmd_valid),
        .i_wdata ({i_cmd_addr0, i_cmd_addr1, i_cmd_count, i_cmd_op}),
        .i_pop   (fifo_pop),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_head  (fifo_head)
    );

    assign {head_addr0, head_addr1, head_count, head_op} = fifo_head;
    assign o_cmd_ready = !fifo_full;
    assign ack_rise    = i_ack && !ack_prev_q;
    assign ack_prev_d  = i_ack;
    assign o_en        = (state_q == ST_EN);
    assign o_valid     = (state_q == ST_SEND) || (state_q == ST_FIN_ACK);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_done_cnt  = done_cnt_q;

    // INFO payload: count in the low bits, op just above, rest zero
    always_comb begin
        info_word = '0;
        info_word[CNT_W-1:0]  = count_q;
        info_word[CNT_W +: 2] = op_q;
    end

    // Instruction presented to the processor; zero whenever not valid
    always_comb begin
        o_instr = '0;
        if (state_q == ST_SEND) begin
            case (idx_q)
                2'd0:    o_instr = make_instr(INSTR_LD, addr0_q);
                2'd1:    o_instr = make_instr(INSTR_LD, addr1_q);
                default: o_instr = make_instr(INSTR_INFO, info_word);
            endcase
        end else if (state_q == ST_FIN_ACK) begin
            o_instr = make_instr(INSTR_FIN, '0);
        end
    end

    // Sequencer next-state: dispatch/drop, issue sequence, finish handshake
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        count_d    = count_q;
        op_d       = op_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        done_cnt_d = done_cnt_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !i_busy) begin
                    fifo_pop = 1'b1;
                    if ((head_count == '0) || (head_op == SIMD_OP_RSVD)) begin
                        err_d = 1'b1;
                    end else begin
                        addr0_d = head_addr0;
                        addr1_d = head_addr1;
                        count_d = head_count;
                        op_d    = head_op;
                        state_d = ST_EN;
                    end
                end
            end
            ST_EN: begin
                idx_d   = 2'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (ack_rise) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (idx_q == 2'd2) begin
                    state_d = ST_WAIT_FIN;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_FIN: begin
                if (i_finish) begin
                    state_d = ST_FIN_ACK;
                end
            end
            ST_FIN_ACK: begin
                state_d = ST_FIN_WAIT_LOW;
            end
            ST_FIN_WAIT_LOW: begin
                if (!i_finish) begin
                    done_d     = 1'b1;
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, working command and status registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            count_q    <= '0;
            op_q       <= '0;
            ack_prev_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            count_q    <= count_d;
            op_q       <= op_d;
            ack_prev_q <= ack_prev_d;
            done_q     <= done_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
        end
    end

endmodule

// File: tb/tb_simd_issuer.sv
// Scoreboard bench for simd_issuer with a small processor model.
module tb_simd_issuer;
    import simd_issuer_pkg::*;

    logic        i_clk, i_rstn;
    logic        i_cmd_valid, o_cmd_ready;
    addr_t       i_cmd_addr0, i_cmd_addr1;
    logic [15:0] i_cmd_count;
    logic [1:0]  i_cmd_op;
    logic        o_en, o_valid, i_ack, i_busy, i_finish, o_done, o_err;
    instr_t      o_instr;
    logic [7:0]  o_done_cnt;

    simd_issuer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr0(i_cmd_addr0), .i_cmd_addr1(i_cmd_addr1),
        .i_cmd_count(i_cmd_count), .i_cmd_op(i_cmd_op),
        .o_en(o_en), .o_valid(o_valid), .o_instr(o_instr),
        .i_ack(i_ack), .i_busy(i_busy), .i_finish(i_finish),
        .o_done(o_done), .o_err(o_err), .o_done_cnt(o_done_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int     n_cmp = 0, n_bad = 0;
    instr_t exp_q[$];
    int     exp_done = 0, exp_err = 0;
    int     done_seen = 0, err_seen = 0, en_seen = 0;
    logic [7:0] model_cnt;
    bit     hold_ack = 0, check_gap = 1, verbose = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input instr_op_t op, input logic [31:0] d);
        instr_t e;
        e.op   = op;
        e.data = d;
        return e;
    endfunction

    // Processor model: acks two cycles into each LD/INFO valid, raises
    // finish shortly after INFO, drops it three cycles after FIN.
    int age = 0, fin_wait = -1, fin_lo = 0;
    initial begin
        i_ack = 0; i_finish = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rstn) begin
                i_ack = 0; i_finish = 0; age = 0; fin_wait = -1; fin_lo = 0;
            end else begin
                if (fin_lo > 0) begin
                    fin_lo--;
                    if (fin_lo == 0) i_finish = 0;
                end
                if (fin_wait > 0) begin
                    fin_wait--;
                    if (fin_wait == 0) begin i_finish = 1; fin_wait = -1; end
                end
                if (o_valid && o_instr.op != INSTR_FIN) begin
                    age++;
                    if (hold_ack) begin
                        if (age == 2) i_ack = 1;
                    end else begin
                        i_ack = (age >= 2) && !i_ack;
                    end
                    if (i_ack && age >= 2 && o_instr.op == INSTR_INFO && fin_wait < 0 && !i_finish)
                        fin_wait = 2;
                end else begin
                    age = 0;
                    if (!hold_ack) i_ack = 0;
                end
                if (o_valid && o_instr.op == INSTR_FIN) fin_lo = 3;
            end
        end
    end

    // Monitor: pops the scoreboard on each new valid instruction
    bit        prev_valid = 0;
    int        valid_run = 0, low_run = 0;
    instr_t    cur_exp;
    instr_op_t last_op = INSTR_FIN;
    initial begin
        model_cnt = 8'd0;
        forever begin
            @(negedge i_clk);
            if (!i_rstn) begin
                prev_valid = 0; valid_run = 0; low_run = 0;
                model_cnt = 8'd0; last_op = INSTR_FIN;
            end else begin
                if (!o_valid) chk("instr_zero_idle", 64'(o_instr), 64'd0);
                if (o_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_instr: got 0x%0h expected none", o_instr);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        if (check_gap && (cur_exp.op == INSTR_INFO ||
                            (cur_exp.op == INSTR_LD && last_op == INSTR_LD)))
                            chk("gap_len", 64'(low_run), 64'd1);
                        chk("instr", 64'(o_instr), 64'(cur_exp));
                        last_op = cur_exp.op;
                        if (verbose)
                            $display("instr op=%0d data=0x%0h (expected op=%0d data=0x%0h)",
                                     o_instr.op, o_instr.data, cur_exp.op, cur_exp.data);
                    end
                end else if (o_valid && prev_valid) begin
                    chk("instr_stable", 64'(o_instr), 64'(cur_exp));
                end
                if (!o_valid && prev_valid && last_op == INSTR_FIN)
                    chk("fin_len", 64'(valid_run), 64'd1);
                if (o_valid) begin
                    if (!prev_valid) valid_run = 0;
                    valid_run++; low_run = 0;
                end else begin
                    if (prev_valid) low_run = 0;
                    low_run++;
                end
                if (o_done) begin
                    done_seen++;
                    model_cnt = model_cnt + 8'd1;
                    chk("done_cnt", 64'(o_done_cnt), 64'(model_cnt));
                end
                if (o_err) err_seen++;
                if (o_en) en_seen++;
                prev_valid = o_valid;
            end
        end
    end

    // Offers one command (caller is at a negedge) and queues its expected instructions
    task automatic push_cmd(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [15:0] cnt, input logic [1:0] op);
        int waited = 0;
        i_cmd_valid = 1; i_cmd_addr0 = a0; i_cmd_addr1 = a1;
        i_cmd_count = cnt; i_cmd_op = op;
        if (cnt == 16'd0 || op == 2'd3) begin
            exp_err++;
        end else begin
            exp_q.push_back(mk(INSTR_LD, a0));
            exp_q.push_back(mk(INSTR_LD, a1));
            exp_q.push_back(mk(INSTR_INFO, {14'd0, op, cnt}));
            exp_q.push_back(mk(INSTR_FIN, 32'd0));
            exp_done++;
        end
        while (!o_cmd_ready && waited < 500) begin @(negedge i_clk); waited++; end
        if (!o_cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: got ready=0 expected ready=1 within 500 cycles");
        end
        @(negedge i_clk);
        i_cmd_valid = 0;
        if (verbose)
            $display("push a0=0x%0h a1=0x%0h count=%0d op=%0d waited=%0d", a0, a1, cnt, op, waited);
    endtask

    task automatic wait_quiet(input string tag);
        int c = 0;
        while ((done_seen != exp_done || err_seen != exp_err || exp_q.size() != 0) && c < 20000) begin
            @(negedge i_clk); c++;
        end
        repeat (3) @(negedge i_clk);
        chk({tag, "_done"}, 64'(done_seen), 64'(exp_done));
        chk({tag, "_err"}, 64'(err_seen), 64'(exp_err));
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    int en0, err0, done0, c;
    logic [31:0] a;

    initial begin
        i_rstn = 0; i_cmd_valid = 0; i_cmd_addr0 = '0; i_cmd_addr1 = '0;
        i_cmd_count = '0; i_cmd_op = '0; i_busy = 0;
        repeat (2) @(negedge i_clk);
        chk("rst_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst_en", 64'(o_en), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_instr", 64'(o_instr), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_done_cnt", 64'(o_done_cnt), 64'd0);
        i_rstn = 1;
        @(negedge i_clk);

        // Basic sequence: LD 0x100, LD 0x200, INFO 0x10004, FIN
        push_cmd(32'h100, 32'h200, 16'd4, 2'd1);
        wait_quiet("basic");

        // Held ack: second LD stalls until ack falls and rises again
        hold_ack = 1; check_gap = 0;
        push_cmd(32'h300, 32'h400, 16'd7, 2'd2);
        c = 0;
        while (!(o_valid && o_instr == mk(INSTR_LD, 32'h400)) && c < 200) begin @(negedge i_clk); c++; end
        repeat (8) @(negedge i_clk);
        chk("stall_valid", 64'(o_valid), 64'd1);
        chk("stall_instr", 64'(o_instr), 64'(mk(INSTR_LD, 32'h400)));
        #1 hold_ack = 0;
        wait_quiet("hold");
        check_gap = 1;

        // FIFO full: five pushes with processor busy
        i_busy = 1;
        for (int i = 0; i < 4; i++) push_cmd(32'h1000 + 32'(i), 32'h2000 + 32'(i), 16'(i + 1), 2'd0);
        chk("full_ready", 64'(o_cmd_ready), 64'd0);
        fork
            push_cmd(32'h1004, 32'h2004, 16'd5, 2'd2);
            begin
                repeat (3) @(negedge i_clk);
                chk("still_full", 64'(o_cmd_ready), 64'd0);
                i_busy = 0;
                @(negedge i_clk);
                chk("ready_after_pop", 64'(o_cmd_ready), 64'd1);
            end
        join
        wait_quiet("full");

        // Zero count dropped, next command dispatched
        en0 = en_seen; err0 = err_seen; done0 = done_seen;
        push_cmd(32'h500, 32'h600, 16'd0, 2'd0);
        push_cmd(32'h700, 32'h800, 16'hFFFF, 2'd0);
        wait_quiet("drop0");
        chk("drop0_en", 64'(en_seen - en0), 64'd1);
        chk("drop0_err", 64'(err_seen - err0), 64'd1);
        chk("drop0_done", 64'(done_seen - done0), 64'd1);

        // Reserved op dropped without enable
        en0 = en_seen;
        push_cmd(32'h900, 32'hA00, 16'd3, 2'd3);
        wait_quiet("drop3");
        chk("drop3_en", 64'(en_seen - en0), 64'd0);

        // Run the retired-command counter around to zero
        verbose = 0;
        while (exp_done < 256) begin
            a = 32'(exp_done) << 4;
            push_cmd(a, a + 32'h8, 16'(exp_done), 2'(exp_done % 3));
        end
        wait_quiet("wrap");
        verbose = 1;
        chk("wrap_total", 64'(done_seen), 64'd256);
        chk("wrap_cnt", 64'(o_done_cnt), 64'd0);
        push_cmd(32'hB00, 32'hC00, 16'd2, 2'd1);
        wait_quiet("post_wrap");
        chk("post_wrap_cnt", 64'(o_done_cnt), 64'd1);

        // Reset during the gap after the second LD, with a second command queued
        done0 = done_seen;
        push_cmd(32'hD00, 32'hE00, 16'd9, 2'd0);
        push_cmd(32'hF00, 32'h1F00, 16'd1, 2'd1);
        c = 0;
        while (!(o_valid && o_instr == mk(INSTR_LD, 32'hE00)) && c < 200) begin @(negedge i_clk); c++; end
        c = 0;
        while (o_valid && c < 50) begin @(negedge i_clk); c++; end
        en0 = en_seen;
        #2 i_rstn = 0;
        exp_q.delete();
        exp_done -= 2;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_done_cnt", 64'(o_done_cnt), 64'd0);
        @(negedge i_clk);
        chk("rst2_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst2_en", 64'(o_en), 64'd0);
        chk("rst2_instr", 64'(o_instr), 64'd0);
        chk("rst2_done", 64'(o_done), 64'd0);
        chk("rst2_err", 64'(o_err), 64'd0);
        i_rstn = 1;
        repeat (6) @(negedge i_clk);
        chk("rst2_no_dispatch", 64'(en_seen), 64'(en0));
        chk("rst2_no_done", 64'(done_seen), 64'(done0));
        push_cmd(32'h1234, 32'h5678, 16'd3, 2'd2);
        wait_quiet("after_rst");
        chk("after_rst_cnt", 64'(o_done_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/simd_issuer.md
SIMD_ISSUER -- requirements
Module: simd_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO depth (power of two, at least 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the command element count.
REQ-003 SHALL have port i_clk, input, 1, clock.
REQ-004 SHALL have port i_rstn, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port i_cmd_valid, input, 1, command offered.
REQ-006 SHALL have port o_cmd_ready, output, 1, FIFO not full.
REQ-007 SHALL have port i_cmd_addr0, input, addr_t, source operand 0 base address.
REQ-008 SHALL have port i_cmd_addr1, input, addr_t, source operand 1 base address.
REQ-009 SHALL have port i_cmd_count, input, CNT_W, number of 128-bit vector operations.
REQ-010 SHALL have port i_cmd_op, input, 2, SIMD opcode: 0 add, 1 mul, 2 sub, 3 reserved.
REQ-011 SHALL have port o_en, output, 1, processor enable.
REQ-012 SHALL have port o_valid, output, 1, instruction valid to processor.
REQ-013 SHALL have port o_instr, output, instr_t, instruction to processor.
REQ-014 SHALL have port i_ack, input, 1, processor instruction acknowledge.
REQ-015 SHALL have port i_busy, input, 1, processor not idle.
REQ-016 SHALL have port i_finish, input, 1, processor completed command.
REQ-017 SHALL have port o_done, output, 1, one-cycle pulse per retired command.
REQ-018 SHALL have port o_err, output, 1, one-cycle pulse per dropped command.
REQ-019 SHALL have port o_done_cnt, output, 8, retired-command counter, wraps 255->0.

Function
REQ-020 Command push on i_cmd_valid && o_cmd_ready; o_cmd_ready = !full; simultaneous push and pop when full is not possible; push and pop in the same cycle when not full and not empty are both performed.
REQ-021 FSM states: IDLE, EN, SEND, GAP, WAIT_FIN, FIN_ACK, FIN_WAIT_LOW.
REQ-022 IDLE: if FIFO not empty and !i_busy, pop the head into working registers. A count of 0 or op 3 causes an o_err pulse and a drop, with the state staying IDLE. Any other command goes to EN.
REQ-023 EN: o_en=1 for exactly one cycle; set seq index to 0; go to SEND.
REQ-024 Instruction sequence, in order:
- idx0: {INSTR_LD, addr0}
- idx1: {INSTR_LD, addr1}
- idx2: {INSTR_INFO, info}, with info[CNT_W-1:0]=count, info[CNT_W+1:CNT_W]=op, remaining bits 0.
REQ-025 SEND: o_valid=1 and o_instr stable. An ack is accepted only on a rising i_ack (i_ack high, previous-cycle i_ack low). On acceptance, go to GAP; o_valid drops in the same cycle as the transition.
REQ-026 GAP: o_valid=0 for exactly one cycle; i_ack is ignored. Then idx<2 -> idx+1 and SEND; idx==2 -> WAIT_FIN.
REQ-027 WAIT_FIN: o_valid=0; i_finish high -> FIN_ACK.
REQ-028 FIN_ACK: o_valid=1 with o_instr={INSTR_FIN, 0} for one cycle; go to FIN_WAIT_LOW.
REQ-029 FIN_WAIT_LOW: on i_finish low, pulse o_done, increment o_done_cnt, go to IDLE.
REQ-030 An i_ack rising edge outside SEND SHALL be ignored, with no state change.
REQ-031 The IDLE-to-EN pop occurs at the earliest in the cycle after the push, so FIFO latency is at least 1 cycle.
REQ-032 o_instr SHALL be 0 whenever o_valid=0.

Reset
REQ-033 On i_rstn low: state IDLE, FIFO emptied, all outputs 0 except o_cmd_ready=1, o_done_cnt=0, and the i_ack edge register 0.
REQ-034 Reset mid-sequence abandons the in-flight command without an o_done or o_err pulse.

Structure
REQ-035 addr_t, instr_t, and the opcodes INSTR_LD, INSTR_INFO and INSTR_FIN SHALL live in the shared defines package; INSTR_FIN is a new opcode added there.
REQ-036 The command FIFO SHALL be a sub-module named cmd_fifo, synchronous read with a registered head, parameterized on width and depth.
REQ-037 State encoding SHALL be localparams inside simd_issuer.

Verification
REQ-038 Push {addr0=0x100, addr1=0x200, count=4, op=1}, with the processor model acking 2 cycles after each valid -> o_instr sequence LD 0x100, LD 0x200, INFO 0x10004; one GAP cycle after each ack.
REQ-039 Model holds i_ack high continuously -> only the first LD is accepted; the issuer stalls in SEND idx1 until i_ack falls and rises again.
REQ-040 Push 5 commands back-to-back with FIFO_DEPTH=4 and the processor stalled -> o_cmd_ready=0 after the 4th push, rising again after the first pop.
REQ-041 Push count=0, then a valid command -> one o_err pulse, no o_en for the first command, the second dispatched normally, o_done_cnt=1.
REQ-042 Model asserts i_finish, then deasserts it 3 cycles after the FIN instruction -> one FIN valid cycle, o_done pulses once, o_done_cnt increments by 1; 256 commands -> o_done_cnt wraps to 0.
REQ-043 Assert i_rstn low during GAP idx1 -> all outputs at reset values next cycle, no o_done, FIFO empty.
